// File: rtl/cpu_controller_p_if.sv
// Control bus between the CPU controller and the datapath/memory side.
// The master modport is the controller; the slave modport is the datapath.
interface cpu_controller_p_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [2:0]       opcode;
    logic [1:0]       ALU_op;
    logic             mem_rdy;

    logic             waiting;
    logic [1:0]       reg_sel;
    logic [1:0]       wb_sel;
    logic             w_en;
    logic             en_A;
    logic             en_B;
    logic             en_C;
    logic             en_status;
    logic             sel_A;
    logic             sel_B;
    logic             mem_req;
    logic             mem_we;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, opcode, ALU_op, mem_rdy,
        output waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, mem_req, mem_we, halted, err, instr_count
    );

    modport slave (
        output start, opcode, ALU_op, mem_rdy,
        input  waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, mem_req, mem_we, halted, err, instr_count
    );
endinterface

// File: rtl/cpu_controller_p.sv
// Multi-cycle controller for the lab CPU: ALU/MOV/LDR/STR/HALT sequencing,
// memory ready handshake with timeout, sticky halt/error and retired count.
module cpu_controller_p #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    cpu_controller_p_if.master bus
);
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [3:0] S_WAIT   = 4'd0;
    localparam logic [3:0] S_WIMM   = 4'd1;
    localparam logic [3:0] S_LOAD_A = 4'd2;
    localparam logic [3:0] S_LOAD_B = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_WB     = 4'd5;
    localparam logic [3:0] S_ADDR   = 4'd6;
    localparam logic [3:0] S_MEM    = 4'd7;
    localparam logic [3:0] S_WBM    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;
    localparam logic [3:0] S_ERR    = 4'd10;

    logic [3:0]       state, state_n;
    logic [2:0]       op_q;
    logic [1:0]       alu_q;
    logic [TW-1:0]    tcnt;
    logic [CNT_W-1:0] count;
    logic             retire;
    logic             is_mem, is_str, is_cmp, is_mov;

    assign is_str = (op_q == OP_STR);
    assign is_mem = (op_q == OP_LDR) || is_str;
    assign is_cmp = (op_q == OP_ALU) && (alu_q == 2'b01);
    assign is_mov = (op_q == OP_MOV);

    // The WAIT decode uses the live opcode; later states use the latched copy.
    always_comb begin
        state_n = state;
        retire  = 1'b0;
        case (state)
            S_WAIT: begin
                if (bus.start) begin
                    case (bus.opcode)
                        OP_MOV:         state_n = (bus.ALU_op == 2'b10) ? S_WIMM : S_LOAD_B;
                        OP_ALU:         state_n = (bus.ALU_op == 2'b11) ? S_LOAD_B : S_LOAD_A;
                        OP_LDR, OP_STR: state_n = S_LOAD_A;
                        OP_HALT:        state_n = S_HALT;
                        default:        state_n = S_ERR;
                    endcase
                end
            end
            S_WIMM, S_WB, S_WBM: begin
                state_n = S_WAIT;
                retire  = 1'b1;
            end
            S_LOAD_A: state_n = is_mem ? S_ADDR : S_LOAD_B;
            S_LOAD_B: state_n = is_str ? S_MEM : S_EXEC;
            S_EXEC: begin
                if (is_cmp) begin
                    state_n = S_WAIT;
                    retire  = 1'b1;
                end else begin
                    state_n = S_WB;
                end
            end
            S_ADDR: state_n = is_str ? S_LOAD_B : S_MEM;
            S_MEM: begin
                // A ready on the final allowed cycle still counts as success.
                if (bus.mem_rdy) begin
                    if (is_str) begin
                        state_n = S_WAIT;
                        retire  = 1'b1;
                    end else begin
                        state_n = S_WBM;
                    end
                end else if (tcnt == T_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_HALT:  state_n = S_HALT;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_WAIT;
            op_q  <= '0;
            alu_q <= '0;
            tcnt  <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            if (state == S_WAIT && bus.start) begin
                op_q  <= bus.opcode;
                alu_q <= bus.ALU_op;
            end
            if (state != S_MEM) begin
                tcnt <= '0;
            end else if (!bus.mem_rdy) begin
                tcnt <= tcnt + TW'(1);
            end
            if (retire && count != '1) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.waiting   = 1'b0;
        bus.reg_sel   = 2'b00;
        bus.wb_sel    = 2'b00;
        bus.w_en      = 1'b0;
        bus.en_A      = 1'b0;
        bus.en_B      = 1'b0;
        bus.en_C      = 1'b0;
        bus.en_status = 1'b0;
        bus.sel_A     = 1'b0;
        bus.sel_B     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.halted    = 1'b0;
        bus.err       = 1'b0;
        case (state)
            S_WAIT: bus.waiting = 1'b1;
            S_WIMM: begin
                bus.reg_sel = 2'b10;
                bus.wb_sel  = 2'b10;
                bus.w_en    = 1'b1;
            end
            S_LOAD_A: begin
                bus.reg_sel = 2'b10;
                bus.en_A    = 1'b1;
            end
            S_LOAD_B: begin
                bus.reg_sel = is_str ? 2'b01 : 2'b00;
                bus.en_B    = 1'b1;
            end
            S_EXEC: begin
                bus.sel_A     = is_mov;
                bus.en_C      = !is_cmp;
                bus.en_status = is_cmp;
            end
            S_WB: begin
                bus.reg_sel = 2'b01;
                bus.w_en    = 1'b1;
            end
            S_ADDR: begin
                bus.sel_B = 1'b1;
                bus.en_C  = 1'b1;
            end
            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = is_str;
            end
            S_WBM: begin
                bus.reg_sel = 2'b01;
                bus.wb_sel  = 2'b01;
                bus.w_en    = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            S_ERR:   bus.err    = 1'b1;
            default: bus.err    = 1'b1;
        endcase
    end

    assign bus.instr_count = count;
endmodule
